mem_arb: RTL and testbench
==========================

# mem_arb

Two-port arbiter that shares one single-port unified memory between the instruction-fetch port and the load/store data port of the core. It replaces the separate instruction and data memories, so the core can use one memory array with a variable-latency req/ack handshake. Requesters see a simple req/ack protocol. Data accesses have priority, and a streak counter bounds how long a fetch can be starved.

## Interface
Parameters:
- ADDR_W, 32, address width on all ports
- DATA_W, 32, data width on all ports
- MAX_D_STREAK, 4, maximum consecutive data grants while a fetch waits (≥1)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  ADDR_W  fetch address, stable while i_req
- i_rdata  out  DATA_W  fetch data, valid with i_ack
- i_ack  out  1  one-cycle completion pulse to fetch port
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_ack
- d_ack  out  1  one-cycle completion pulse to data port
- m_req  out  1  memory request, held until m_ack
- m_we  out  1  memory write enable
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid with m_ack
- m_ack  in  1  memory completion, may be asserted as early as the first m_req cycle

## Operation
- States: IDLE, GNT_I, GNT_D, RESP.
- IDLE, selection in priority order:
  - d_req only: go to GNT_D.
  - i_req only: go to GNT_I.
  - Both requesting: GNT_D, unless streak == MAX_D_STREAK, in which case GNT_I.
  - Neither: stay in IDLE.
- On grant (IDLE→GNT_x edge), register m_addr/m_we/m_wdata from the winning port and set m_req=1. For the fetch port, m_we=0 and m_wdata=0.
- GNT_x: hold m_req and the captured fields until m_ack. On m_ack:
  - m_req←0.
  - On reads, capture m_rdata into x_rdata. On stores, d_rdata is unchanged.
  - x_ack←1 for one cycle.
  - Next state RESP.
- RESP: x_ack deasserts. All requests are ignored this cycle, because the acked requester still shows req=1 here. Then go to IDLE.
- Streak counter, width $clog2(MAX_D_STREAK+1):
  - D grant with i_req=1: increment, saturating at MAX_D_STREAK.
  - D grant with i_req=0: clear to 0.
  - Any I grant: clear to 0.
- m_ack outside GNT_I/GNT_D is ignored.
- Requester inputs are sampled only in IDLE. Changes at any other time have no effect.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, streak=0.
  - m_req, m_we, m_addr, m_wdata, i_ack, d_ack, i_rdata, d_rdata all 0.
  - An in-flight transaction is abandoned with no ack. m_req drops immediately.
- All outputs are registered. There are no combinational input-to-output paths.
- Latency with req seen in IDLE at cycle 0:
  - m_req high from cycle 1.
  - m_ack at cycle k≥1 gives x_ack at k+1.
  - Arbiter is back in IDLE at k+2.
  - Minimum is 2 cycles req→ack, with one transaction per 3 cycles.
- The requester drops req in the cycle it sees ack. It may re-raise req from the following cycle.
- Reset release is synchronised by the environment. The first grant is possible in the first cycle after release.

## Structure
- Shared package napalm_pkg holds:
  - the arb_state_t enum (IDLE, GNT_I, GNT_D, RESP);
  - default constants ARB_ADDR_W, ARB_DATA_W, ARB_MAX_D_STREAK.
- One sub-module: arb_streak_ctr, the saturating streak counter with inc/clr inputs and a sat output. Everything else is flat in mem_arb.

## Test plan
- Reset: hold rst=0 with i_req=d_req=1 → all outputs 0. Release → m_req=1 with m_addr=d_addr in the first cycle after release.
- Single load: d_req, d_we=0, d_addr=0x40; memory acks in 3 cycles with 0xDEADBEEF → d_ack pulses once, d_rdata=0xDEADBEEF, i_ack stays 0.
- Store: d_we=1, d_addr=0x80, d_wdata=0x1234 → m_we=1, m_addr=0x80, m_wdata=0x1234 until m_ack. d_ack then pulses one cycle later, d_rdata unchanged.
- Contention and starvation bound (MAX_D_STREAK=4): i_req and d_req both held continuously, zero-wait memory → grant order D,D,D,D,I,D,D,D,D,I.
- Back-to-back requests: requester re-raises req the cycle after ack → no duplicate grant in RESP, and exactly one m_req burst per request.
- Reset mid-transaction: rst=0 while in GNT_I with m_req=1 → m_req=0 asynchronously, no i_ack. After release, a fresh i_req completes normally.

Source files
------------

// File: rtl/napalm_pkg.sv
// napalm_pkg: shared types and default sizing for the unified-memory arbiter.
//   arb_state_t       : arbiter FSM state encoding (IDLE, GNT_I, GNT_D, RESP)
//   ARB_ADDR_W        : default address width
//   ARB_DATA_W        : default data width
//   ARB_MAX_D_STREAK  : default bound on consecutive data grants while a fetch waits
package napalm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int ARB_ADDR_W       = 32;
  localparam int ARB_DATA_W       = 32;
  localparam int ARB_MAX_D_STREAK = 4;

endpackage

// File: rtl/arb_streak_ctr.sv
// arb_streak_ctr: saturating counter of consecutive data grants issued while a
// fetch was waiting.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   inc  : count one more data grant (saturates at MAX)
//   clr  : clear to zero (wins over inc)
//   sat  : count has reached MAX; the next contended grant goes to fetch
module arb_streak_ctr
  import napalm_pkg::*;
#(
  parameter int MAX = ARB_MAX_D_STREAK
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_max;

  assign at_max = (cnt_q == CW'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = at_max;

endmodule

// File: rtl/mem_arb.sv
// mem_arb: shares one single-port memory between the fetch port (i_*) and the
// load/store port (d_*). Data has priority; after MAX_D_STREAK consecutive data
// grants taken while a fetch waits, the fetch wins the next contended grant.
//
// Handshake (all three ports): a requester raises req with stable fields and
// holds it until it sees its ack; ack is a single-cycle pulse and read data is
// valid in that same cycle. m_req is held with stable m_we/m_addr/m_wdata
// until m_ack, which may arrive in the first m_req cycle.
//
// Ports:
//   clk, rst                         clock, async active-low reset
//   i_req, i_addr / i_rdata, i_ack   fetch port
//   d_req, d_we, d_addr, d_wdata /
//   d_rdata, d_ack                   load/store port
//   m_req, m_we, m_addr, m_wdata /
//   m_rdata, m_ack                   memory port
//   dbg_state                        current FSM state, for observation only
module mem_arb
  import napalm_pkg::*;
#(
  parameter int ADDR_W       = ARB_ADDR_W,
  parameter int DATA_W       = ARB_DATA_W,
  parameter int MAX_D_STREAK = ARB_MAX_D_STREAK
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  // load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  // memory port
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  // observation
  output arb_state_t        dbg_state
);

  arb_state_t        state_q, state_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic streak_inc;
  logic streak_clr;
  logic streak_sat;
  logic d_wins;

  arb_streak_ctr #(
    .MAX (MAX_D_STREAK)
  ) u_streak (
    .clk (clk),
    .rst (rst),
    .inc (streak_inc),
    .clr (streak_clr),
    .sat (streak_sat)
  );

  // Data wins unless a fetch is also waiting and has already been passed over
  // MAX_D_STREAK times in a row.
  assign d_wins = d_req && !(i_req && streak_sat);

  always_comb begin
    state_d    = state_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_ack_d    = 1'b0;
    d_ack_d    = 1'b0;
    streak_inc = 1'b0;
    streak_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (d_wins) begin
          state_d    = GNT_D;
          m_req_d    = 1'b1;
          m_we_d     = d_we;
          m_addr_d   = d_addr;
          m_wdata_d  = d_wdata;
          // Only grants taken over a waiting fetch extend the streak.
          streak_inc = i_req;
          streak_clr = !i_req;
        end else if (i_req) begin
          state_d    = GNT_I;
          m_req_d    = 1'b1;
          m_we_d     = 1'b0;
          m_addr_d   = i_addr;
          m_wdata_d  = '0;
          streak_clr = 1'b1;
        end
      end

      GNT_I: begin
        if (m_ack) begin
          state_d   = RESP;
          m_req_d   = 1'b0;
          i_rdata_d = m_rdata;
          i_ack_d   = 1'b1;
        end
      end

      GNT_D: begin
        if (m_ack) begin
          state_d = RESP;
          m_req_d = 1'b0;
          d_ack_d = 1'b1;
          if (!m_we_q) begin
            d_rdata_d = m_rdata;
          end
        end
      end

      // The acked requester still shows req=1 in this cycle, so nothing is
      // sampled here; arbitration resumes from IDLE next cycle.
      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
    end
  end

  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed bench for mem_arb with an ack scoreboard, a memory
// responder model and a grant log.
module tb_mem_arb;
  import napalm_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic          i_req, i_ack, d_req, d_we, d_ack, m_req, m_we, m_ack;
  logic [AW-1:0] i_addr, d_addr, m_addr;
  logic [DW-1:0] i_rdata, d_wdata, d_rdata, m_wdata, m_rdata;
  arb_state_t    dbg_state;

  mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_i_q[$];
  logic [DW-1:0] exp_d_q[$];

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gnt_t;
  gnt_t gnt_log[$];

  int mem_lat = 0;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0], 16'hC0DE};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int cnt;
    cnt = 0;
    m_ack = 1'b0;
    m_rdata = 32'hBAD0BAD0;
    forever begin
      @(posedge clk); #1;
      if (m_req) begin
        if (cnt >= mem_lat) begin
          m_ack = 1'b1;
          m_rdata = mem_data(m_addr);
        end else begin
          m_ack = 1'b0;
          m_rdata = 32'hBAD0BAD0;
          cnt++;
        end
      end else begin
        m_ack = 1'b0;
        m_rdata = 32'hBAD0BAD0;
        cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_mreq = 1'b0;
  gnt_t cur_gnt;
  logic burst_bad = 1'b0;

  always @(negedge clk) begin
    if (m_req && !prev_mreq) begin
      cur_gnt.we = m_we;
      cur_gnt.addr = m_addr;
      cur_gnt.wdata = m_wdata;
      gnt_log.push_back(cur_gnt);
      burst_bad = 1'b0;
    end else if (m_req && prev_mreq) begin
      if (m_we !== cur_gnt.we || m_addr !== cur_gnt.addr || m_wdata !== cur_gnt.wdata)
        burst_bad = 1'b1;
    end
    if (!m_req && prev_mreq) check("m_fields_stable", 64'(burst_bad), 64'd0);
    prev_mreq = m_req;

    if (i_ack && d_ack) check("both_acks", 64'd1, 64'd0);
    if (i_ack) begin
      if (exp_i_q.size() == 0) check("unexpected_i_ack", 64'd1, 64'd0);
      else check("i_rdata", 64'(i_rdata), 64'(exp_i_q.pop_front()));
    end
    if (d_ack) begin
      if (exp_d_q.size() == 0) check("unexpected_d_ack", 64'd1, 64'd0);
      else check("d_rdata", 64'(d_rdata), 64'(exp_d_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns cycles until ack seen. Req stays high through
  // the ack cycle and drops one cycle later, as a registered requester would.
  task automatic wait_d_ack(output int n);
    n = 0;
    while (!d_ack && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!d_ack) check("d_ack_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic wait_i_ack(output int n);
    n = 0;
    while (!i_ack && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!i_ack) check("i_ack_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic d_xact(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                        output int n);
    d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    exp_d_q.push_back(exp_rdata);
    wait_d_ack(n);
  endtask

  task automatic i_xact(input logic [AW-1:0] addr, input logic [DW-1:0] exp_rdata,
                        output int n);
    i_addr = addr; i_req = 1'b1;
    exp_i_q.push_back(exp_rdata);
    wait_i_ack(n);
  endtask

  task automatic chk_gnt(input int idx, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
    if (idx >= gnt_log.size()) begin
      check("gnt_missing", 64'(gnt_log.size()), 64'(idx + 1));
    end else begin
      check("gnt_we", 64'(gnt_log[idx].we), 64'(we));
      check("gnt_addr", 64'(gnt_log[idx].addr), 64'(addr));
      check("gnt_wdata", 64'(gnt_log[idx].wdata), 64'(wdata));
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, nd, ni, base;

    // Reset held with both ports requesting.
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h3000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_wdata = '0;
    mem_lat = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_req", 64'(m_req), 64'd0);
    check("rst_m_we", 64'(m_we), 64'd0);
    check("rst_m_addr", 64'(m_addr), 64'd0);
    check("rst_m_wdata", 64'(m_wdata), 64'd0);
    check("rst_i_ack", 64'(i_ack), 64'd0);
    check("rst_d_ack", 64'(d_ack), 64'd0);
    check("rst_i_rdata", 64'(i_rdata), 64'd0);
    check("rst_d_rdata", 64'(d_rdata), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    exp_d_q.push_back(32'h0044C0DE);
    exp_i_q.push_back(32'h3000C0DE);
    rst = 1'b1;
    @(posedge clk); #1;
    check("first_grant_m_req", 64'(m_req), 64'd1);
    check("first_grant_m_addr", 64'(m_addr), 64'h44);
    fork
      wait_d_ack(nd);
      wait_i_ack(ni);
    join
    chk_gnt(0, 1'b0, 32'h44, 32'h0);
    chk_gnt(1, 1'b0, 32'h3000, 32'h0);

    // Single load, memory acks on the third m_req cycle.
    mem_lat = 2;
    base = gnt_log.size();
    d_xact(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, n);
    check("load_latency", 64'(n), 64'd4);
    chk_gnt(base, 1'b0, 32'h40, 32'h0);

    // Store: d_rdata keeps the previous load value.
    base = gnt_log.size();
    d_xact(1'b1, 32'h80, 32'h1234, 32'hDEADBEEF, n);
    chk_gnt(base, 1'b1, 32'h80, 32'h1234);

    // Back-to-back with zero-wait memory.
    mem_lat = 0;
    base = gnt_log.size();
    d_xact(1'b0, 32'h48, 32'h0, 32'h0048C0DE, n);
    check("b2b_latency0", 64'(n), 64'd2);
    d_xact(1'b0, 32'h4C, 32'h0, 32'h004CC0DE, n);
    check("b2b_latency1", 64'(n), 64'd2);
    d_xact(1'b1, 32'h50, 32'h55AA, 32'h004CC0DE, n);
    check("b2b_latency2", 64'(n), 64'd2);
    i_xact(32'h2100, 32'h2100C0DE, n);
    check("fetch_latency", 64'(n), 64'd2);
    check("b2b_burst_count", 64'(gnt_log.size() - base), 64'd4);
    chk_gnt(base + 0, 1'b0, 32'h48, 32'h0);
    chk_gnt(base + 1, 1'b0, 32'h4C, 32'h0);
    chk_gnt(base + 2, 1'b1, 32'h50, 32'h55AA);
    chk_gnt(base + 3, 1'b0, 32'h2100, 32'h0);

    // Contention: expected order D,D,D,D,I,D,D,D,D,I.
    base = gnt_log.size();
    fork
      begin
        int dn;
        for (int k = 0; k < 8; k++)
          d_xact(1'b0, 32'h100 + 32'(4 * k), 32'h0, mem_data(32'h100 + 32'(4 * k)), dn);
      end
      begin
        int in_n;
        for (int k = 0; k < 2; k++)
          i_xact(32'h2000 + 32'(4 * k), mem_data(32'h2000 + 32'(4 * k)), in_n);
      end
    join
    check("contention_count", 64'(gnt_log.size() - base), 64'd10);
    chk_gnt(base + 0, 1'b0, 32'h100, 32'h0);
    chk_gnt(base + 1, 1'b0, 32'h104, 32'h0);
    chk_gnt(base + 2, 1'b0, 32'h108, 32'h0);
    chk_gnt(base + 3, 1'b0, 32'h10C, 32'h0);
    chk_gnt(base + 4, 1'b0, 32'h2000, 32'h0);
    chk_gnt(base + 5, 1'b0, 32'h110, 32'h0);
    chk_gnt(base + 6, 1'b0, 32'h114, 32'h0);
    chk_gnt(base + 7, 1'b0, 32'h118, 32'h0);
    chk_gnt(base + 8, 1'b0, 32'h11C, 32'h0);
    chk_gnt(base + 9, 1'b0, 32'h2004, 32'h0);

    // Reset during GNT_I: abandoned, no ack, m_req drops immediately.
    mem_lat = 5;
    i_addr = 32'h3100; i_req = 1'b1;
    n = 0;
    while (!m_req && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("midrst_m_req_before", 64'(m_req), 64'd1);
    @(posedge clk); #3;
    check("midrst_state_before", 64'(dbg_state), 64'(GNT_I));
    rst = 1'b0;
    #1;
    check("midrst_m_req_async", 64'(m_req), 64'd0);
    check("midrst_m_addr", 64'(m_addr), 64'd0);
    check("midrst_i_ack", 64'(i_ack), 64'd0);
    i_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    mem_lat = 1;
    i_xact(32'h3200, 32'h3200C0DE, n);
    check("post_rst_fetch_latency", 64'(n), 64'd3);

    repeat (4) @(posedge clk);
    check("exp_i_q_empty", 64'(exp_i_q.size()), 64'd0);
    check("exp_d_q_empty", 64'(exp_d_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
